// File: rtl/elevator_pkg.sv
// Shared types for the elevator demo: direction codes consumed by the
// direction display, and the per-car controller state encoding.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN = 2'b00,
    DIR_UP   = 2'b01,
    DIR_IDLE = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    DOOR = 2'b10
  } car_state_t;

endpackage

// File: rtl/elevator_req_scan.sv
// Classifies outstanding floor requests as at, above or below a given floor.
// Purely combinational so a dispatcher can reuse it on any car's bitmap.
module elevator_req_scan #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic                  here_o,
  output logic                  above_o,
  output logic                  below_o
);

  always_comb begin
    here_o  = 1'b0;
    above_o = 1'b0;
    below_o = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_i[i]) begin
        if (i > int'(cur_floor_i))      above_o = 1'b1;
        else if (i < int'(cur_floor_i)) below_o = 1'b1;
        else                            here_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Per-car motion controller: latches calls, scans in the current direction one
// floor per travel interval, and opens the door at each requested floor.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  call_valid_i,
  input  logic [FLOOR_W-1:0]    call_floor_i,
  output logic [FLOOR_W-1:0]    cur_floor_o,
  output logic [1:0]            dir_o,
  output logic                  door_open_o,
  output logic                  moving_o,
  output logic [NUM_FLOORS-1:0] pending_o
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC);

  car_state_t            state_q, state_d;
  logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
  dir_t                  dir_q, dir_d;
  dir_t                  last_dir_q, last_dir_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;

  logic                  here, above, below;
  logic [FLOOR_W-1:0]    next_floor;
  logic [NUM_FLOORS-1:0] cur_bit, next_bit, call_bit;
  logic                  same_floor_call, arrive_hit;

  elevator_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan (
    .pending_i   (pending_q),
    .cur_floor_i (cur_floor_q),
    .here_o      (here),
    .above_o     (above),
    .below_o     (below)
  );

  assign next_floor = (dir_q == DIR_UP) ? cur_floor_q + 1'b1 : cur_floor_q - 1'b1;

  // Out-of-range call floors decode to an all-zero vector and are dropped.
  always_comb begin
    cur_bit  = '0;
    next_bit = '0;
    call_bit = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_bit[i]  = (int'(cur_floor_q) == i);
      next_bit[i] = (int'(next_floor) == i);
      call_bit[i] = call_valid_i && (int'(call_floor_i) == i);
    end
  end

  assign same_floor_call = |(call_bit & cur_bit);
  assign arrive_hit      = |((pending_q | call_bit) & next_bit);

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_d       = dir_q;
    last_dir_d  = last_dir_q;
    timer_d     = timer_q;
    pending_d   = pending_q | call_bit;
    unique case (state_q)
      IDLE: begin
        dir_d     = DIR_IDLE;
        pending_d = (pending_q | call_bit) & ~cur_bit;
        if (here || same_floor_call) begin
          state_d = DOOR;
          timer_d = '0;
        end else if (above && (last_dir_q == DIR_UP || !below)) begin
          state_d    = MOVE;
          dir_d      = DIR_UP;
          last_dir_d = DIR_UP;
          timer_d    = '0;
        end else if (below) begin
          state_d    = MOVE;
          dir_d      = DIR_DOWN;
          last_dir_d = DIR_DOWN;
          timer_d    = '0;
        end
      end
      MOVE: begin
        if (timer_q == TIMER_W'(TRAVEL_CYCLES - 1)) begin
          timer_d     = '0;
          cur_floor_d = next_floor;
          // The scan bits cover next_floor too, but it is known clear here.
          if (arrive_hit) begin
            state_d   = DOOR;
            pending_d = (pending_q | call_bit) & ~next_bit;
          end else if (!((dir_q == DIR_UP) ? above : below)) begin
            state_d = IDLE;
            dir_d   = DIR_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DOOR: begin
        pending_d = (pending_q | call_bit) & ~cur_bit;
        if (same_floor_call) begin
          timer_d = '0;
        end else if (timer_q == TIMER_W'(DOOR_CYCLES - 1)) begin
          state_d = IDLE;
          dir_d   = DIR_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = DIR_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      dir_q       <= DIR_IDLE;
      last_dir_q  <= DIR_UP;
      pending_q   <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_q       <= dir_d;
      last_dir_q  <= last_dir_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
    end
  end

  assign cur_floor_o = cur_floor_q;
  assign dir_o       = dir_q;
  assign door_open_o = (state_q == DOOR);
  assign moving_o    = (state_q == MOVE);
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with short travel/door intervals;
// every expected value below is hand-derived from the cycle-level behaviour.
module tb_elevator_car_ctrl;

  localparam int NUM_FLOORS    = 8;
  localparam int FLOOR_W       = 4;
  localparam int TRAVEL_CYCLES = 4;
  localparam int DOOR_CYCLES   = 3;

  logic                  clk;
  logic                  reset;
  logic                  callValid;
  logic [FLOOR_W-1:0]    callFloor;
  logic [FLOOR_W-1:0]    curFloor;
  logic [1:0]            dir;
  logic                  doorOpen;
  logic                  moving;
  logic [NUM_FLOORS-1:0] pending;

  int checks = 0;
  int errors = 0;

  elevator_car_ctrl #(
    .NUM_FLOORS    (NUM_FLOORS),
    .FLOOR_W       (FLOOR_W),
    .TRAVEL_CYCLES (TRAVEL_CYCLES),
    .DOOR_CYCLES   (DOOR_CYCLES)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .call_valid_i (callValid),
    .call_floor_i (callFloor),
    .cur_floor_o  (curFloor),
    .dir_o        (dir),
    .door_open_o  (doorOpen),
    .moving_o     (moving),
    .pending_o    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one call for exactly one rising edge, then returns just after it.
  task automatic applyStimulus(input logic valid, input logic [FLOOR_W-1:0] floor);
    callValid = valid;
    callFloor = floor;
    @(posedge clk);
    #1;
    callValid = 1'b0;
    callFloor = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    callValid = 1'b0;
    callFloor = '0;
    tick(2);
    reset = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_floor", 32'(curFloor), 0);
    checkOutput("rst_dir", 32'(dir), 32'h2);
    checkOutput("rst_pending", 32'(pending), 0);
    checkOutput("rst_door", 32'(doorOpen), 0);
    checkOutput("rst_moving", 32'(moving), 0);

    // Single call upward from floor 0 to floor 3.
    applyStimulus(1'b1, 4'd3);
    checkOutput("up_pending", 32'(pending), 32'h08);
    checkOutput("up_dir_still_idle", 32'(dir), 32'h2);
    tick(1);
    checkOutput("up_dir", 32'(dir), 32'h1);
    checkOutput("up_moving", 32'(moving), 1);
    checkOutput("up_floor0", 32'(curFloor), 0);
    tick(3);
    checkOutput("up_floor_hold", 32'(curFloor), 0);
    for (int f = 1; f <= 3; f++) begin
      tick(f == 1 ? 1 : 4);
      checkOutput("up_step", 32'(curFloor), 32'(f));
    end
    checkOutput("up_door", 32'(doorOpen), 1);
    checkOutput("up_door_dir", 32'(dir), 32'h1);
    checkOutput("up_served", 32'(pending), 0);
    tick(2);
    checkOutput("up_door_last", 32'(doorOpen), 1);
    tick(1);
    checkOutput("up_door_closed", 32'(doorOpen), 0);
    checkOutput("up_idle_dir", 32'(dir), 32'h2);

    // Scan ordering: at floor 3 (last up), calls 5 then 1.
    applyStimulus(1'b1, 4'd5);
    applyStimulus(1'b1, 4'd1);
    checkOutput("scan_dir_up", 32'(dir), 32'h1);
    checkOutput("scan_pending", 32'(pending), 32'h22);
    tick(4);
    checkOutput("scan_f4", 32'(curFloor), 4);
    checkOutput("scan_pass4_moving", 32'(moving), 1);
    tick(4);
    checkOutput("scan_f5", 32'(curFloor), 5);
    checkOutput("scan_door5", 32'(doorOpen), 1);
    checkOutput("scan_pending_after5", 32'(pending), 32'h02);
    tick(3);
    checkOutput("scan_idle_between", 32'(dir), 32'h2);
    tick(1);
    checkOutput("scan_dir_down", 32'(dir), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick(4);
      checkOutput("scan_down_step", 32'(curFloor), 32'(5 - k));
    end
    checkOutput("scan_door1", 32'(doorOpen), 1);
    checkOutput("scan_all_served", 32'(pending), 0);
    tick(3);

    // Go to floor 2 and settle there.
    applyStimulus(1'b1, 4'd2);
    tick(1);
    checkOutput("to2_dir_up", 32'(dir), 32'h1);
    tick(4);
    checkOutput("to2_floor", 32'(curFloor), 2);
    tick(3);
    checkOutput("to2_idle", 32'(doorOpen), 0);

    // Same-floor call while idle, then a repeat in the door's second cycle.
    applyStimulus(1'b1, 4'd2);
    checkOutput("same_door_open", 32'(doorOpen), 1);
    checkOutput("same_no_bit", 32'(pending), 0);
    checkOutput("same_dir_idle", 32'(dir), 32'h2);
    tick(1);
    applyStimulus(1'b1, 4'd2);
    checkOutput("restart_door", 32'(doorOpen), 1);
    tick(2);
    checkOutput("restart_door_held", 32'(doorOpen), 1);
    checkOutput("restart_no_bit", 32'(pending), 0);
    tick(1);
    checkOutput("restart_door_closed", 32'(doorOpen), 0);

    // Out-of-range call is ignored.
    applyStimulus(1'b1, 4'd9);
    checkOutput("ignore_pending", 32'(pending), 0);
    tick(1);
    checkOutput("ignore_moving", 32'(moving), 0);
    checkOutput("ignore_dir", 32'(dir), 32'h2);

    // Call for floor 4 on the exact cycle the car arrives at 4 (heading to 5).
    applyStimulus(1'b1, 4'd5);
    tick(1);
    checkOutput("coll_moving", 32'(moving), 1);
    tick(7);
    checkOutput("coll_floor3", 32'(curFloor), 3);
    applyStimulus(1'b1, 4'd4);
    checkOutput("coll_floor4", 32'(curFloor), 4);
    checkOutput("coll_door", 32'(doorOpen), 1);
    checkOutput("coll_pending", 32'(pending), 32'h20);
    tick(4);
    checkOutput("coll_resume", 32'(moving), 1);
    tick(4);
    checkOutput("coll_floor5", 32'(curFloor), 5);
    checkOutput("coll_door5", 32'(doorOpen), 1);
    tick(3);

    // Reset mid-MOVE at floor 2 with calls 6 and 7 outstanding.
    applyStimulus(1'b1, 4'd1);
    tick(1);
    checkOutput("mid_dir_down", 32'(dir), 32'h0);
    tick(12);
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b1, 4'd7);
    checkOutput("mid_floor2", 32'(curFloor), 2);
    checkOutput("mid_moving", 32'(moving), 1);
    checkOutput("mid_pending", 32'(pending), 32'hC2);
    reset = 1'b1;
    tick(1);
    checkOutput("mid_rst_floor", 32'(curFloor), 0);
    checkOutput("mid_rst_pending", 32'(pending), 0);
    checkOutput("mid_rst_dir", 32'(dir), 32'h2);
    checkOutput("mid_rst_moving", 32'(moving), 0);
    reset = 1'b0;
    tick(2);
    checkOutput("post_rst_moving", 32'(moving), 0);
    checkOutput("post_rst_door", 32'(doorOpen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
